// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the unified-memory arbiter.
//   WORD_W      : memory word / address width
//   arb_state_t : arbiter FSM states (IDLE, fetch outstanding, data outstanding)
package mem_arbiter_pkg;

  localparam int unsigned WORD_W = 16;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_INST = 2'b01,
    ARB_DATA = 2'b10
  } arb_state_t;

endpackage

// File: rtl/arb_timeout_counter.sv
// Cycle counter guarding an outstanding memory transaction.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : restart count at 0 (wins over enable)
//   enable   : count one more cycle
//   expired  : count has reached TIMEOUT
module arb_timeout_counter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count == CNT_W'(TIMEOUT));

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-ported multi-cycle memory between instruction
// fetch (read-only) and the memory stage (read/write). Data port has fixed
// priority; one transaction outstanding at a time.
//   if_rd/if_addr                 : fetch request, held until if_done
//   dm_rd/dm_wr/dm_addr/dm_wdata  : data request, held until dm_done
//   mem_*                         : memory interface (one-cycle strobes, done pulse)
//   if_rdata/if_done, dm_rdata/dm_done : registered per-port results
//   if_stall/dm_stall             : hold requests for the hazard logic
//   err                           : sticky protocol / timeout error
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_rd,
  input  logic [WORD_W-1:0] if_addr,
  input  logic              dm_rd,
  input  logic              dm_wr,
  input  logic [WORD_W-1:0] dm_addr,
  input  logic [WORD_W-1:0] dm_wdata,
  input  logic              mem_done,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [WORD_W-1:0] if_rdata,
  output logic              if_done,
  output logic              if_stall,
  output logic [WORD_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              dm_stall,
  output logic              err
);

  arb_state_t state_q, state_d;
  logic       dm_is_wr_q, dm_is_wr_d;
  logic       cnt_clear, cnt_en, expired;
  logic       if_fin, dm_fin, err_set;

  arb_timeout_counter #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (cnt_clear),
    .enable  (cnt_en),
    .expired (expired)
  );

  always_comb begin
    state_d    = state_q;
    dm_is_wr_d = dm_is_wr_q;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    cnt_clear  = 1'b0;
    cnt_en     = 1'b0;
    if_fin     = 1'b0;
    dm_fin     = 1'b0;
    err_set    = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (mem_done) err_set = 1'b1;
        // Grants are suppressed while rst is held so no strobe escapes to
        // the memory during reset.
        if (dm_rd && dm_wr) begin
          err_set = 1'b1;
        end else if (!rst && (dm_rd || dm_wr) && !dm_done) begin
          mem_rd     = dm_rd;
          mem_wr     = dm_wr;
          mem_addr   = dm_addr;
          mem_wdata  = dm_wr ? dm_wdata : '0;
          dm_is_wr_d = dm_wr;
          cnt_clear  = 1'b1;
          state_d    = ARB_DATA;
        end else if (!rst && if_rd && !if_done) begin
          mem_rd    = 1'b1;
          mem_addr  = if_addr;
          cnt_clear = 1'b1;
          state_d   = ARB_INST;
        end
      end
      ARB_INST: begin
        cnt_en = 1'b1;
        if (mem_done) begin
          if_fin  = 1'b1;
          state_d = ARB_IDLE;
        end else if (expired) begin
          err_set = 1'b1;
          state_d = ARB_IDLE;
        end
      end
      ARB_DATA: begin
        cnt_en = 1'b1;
        if (mem_done) begin
          dm_fin  = 1'b1;
          state_d = ARB_IDLE;
        end else if (expired) begin
          err_set = 1'b1;
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      dm_is_wr_q <= 1'b0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
      if_done    <= 1'b0;
      dm_done    <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      dm_is_wr_q <= dm_is_wr_d;
      if_done    <= if_fin;
      dm_done    <= dm_fin;
      if (if_fin) if_rdata <= mem_rdata;
      if (dm_fin && !dm_is_wr_q) dm_rdata <= mem_rdata;
      if (err_set) err <= 1'b1;
    end
  end

  // Stalls depend only on registered done, keeping them off the grant path.
  assign if_stall = if_rd & ~if_done;
  assign dm_stall = (dm_rd | dm_wr) & ~dm_done;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int          lat;
  } txn_t;

  logic        clk, rst;
  logic        if_rd, dm_rd, dm_wr, mem_done;
  logic [15:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [15:0] mem_addr, mem_wdata, if_rdata, dm_rdata;
  logic        mem_rd, mem_wr, if_done, if_stall, dm_done, dm_stall, err;

  mem_arbiter #(.TIMEOUT(15), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .if_rd(if_rd), .if_addr(if_addr),
    .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .if_rdata(if_rdata), .if_done(if_done), .if_stall(if_stall),
    .dm_rdata(dm_rdata), .dm_done(dm_done), .dm_stall(dm_stall),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int cd       = -1;
  int n_strobe = 0;
  int last_strobe = 0;
  bit inject_done = 1'b0;
  logic [15:0] cur_rdata = '0;

  txn_t        exp_q[$];
  logic [15:0] if_q[$];
  logic [15:0] dm_q[$];

  logic        s_mem_rd, s_mem_wr, s_if_done, s_dm_done, s_if_stall, s_dm_stall, s_err;
  logic [15:0] s_mem_addr, s_mem_wdata, s_if_rdata, s_dm_rdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory model + scoreboard, evaluated at the negative edge.
  task automatic monitor();
    txn_t t;
    cyc++;
    s_mem_rd = mem_rd;  s_mem_wr = mem_wr;
    s_mem_addr = mem_addr;  s_mem_wdata = mem_wdata;
    s_if_done = if_done;  s_dm_done = dm_done;
    s_if_rdata = if_rdata;  s_dm_rdata = dm_rdata;
    s_if_stall = if_stall;  s_dm_stall = dm_stall;
    s_err = err;
    mem_done = 1'b0;
    if (rst) begin
      cd = -1;
      inject_done = 1'b0;
    end else begin
      if (inject_done) begin
        mem_done = 1'b1;
        inject_done = 1'b0;
      end
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          mem_done  = 1'b1;
          mem_rdata = cur_rdata;
          cd = -1;
        end
      end
    end
    if (s_mem_rd || s_mem_wr) begin
      n_strobe++;
      last_strobe = cyc;
      check("strobe_exclusive", s_mem_rd & s_mem_wr, 0);
      check("strobe_pending", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        t = exp_q.pop_front();
        check("strobe_kind_wr", s_mem_wr, t.wr);
        check("strobe_addr", s_mem_addr, t.addr);
        check("strobe_wdata", s_mem_wdata, t.wdata);
        cur_rdata = t.rdata;
        cd = (t.lat > 0) ? t.lat : -1;
      end
    end
    if (s_if_done) begin
      check("if_done_pending", if_q.size() != 0, 1);
      if (if_q.size() != 0) check("if_rdata", s_if_rdata, if_q.pop_front());
    end
    if (s_dm_done) begin
      check("dm_done_pending", dm_q.size() != 0, 1);
      if (dm_q.size() != 0) check("dm_rdata", s_dm_rdata, dm_q.pop_front());
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit expect_drained);
    if (expect_drained) begin
      check("sb_drained", exp_q.size() + if_q.size() + dm_q.size(), 0);
    end
    rst = 1'b1;
    if_rd = 1'b0; dm_rd = 1'b0; dm_wr = 1'b0;
    exp_q.delete(); if_q.delete(); dm_q.delete();
    cycle();
    cycle();
    check("rst_err", s_err, 0);
    check("rst_if_done", s_if_done, 0);
    check("rst_dm_done", s_dm_done, 0);
    check("rst_if_rdata", s_if_rdata, 0);
    check("rst_dm_rdata", s_dm_rdata, 0);
    check("rst_mem_rd", s_mem_rd, 0);
    rst = 1'b0;
  endtask

  int stall_cnt, t0, bad_done;

  initial begin
    rst = 1'b1; if_rd = 1'b0; dm_rd = 1'b0; dm_wr = 1'b0; mem_done = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
    do_reset(1'b0);

    // 1: fetch only, L=3
    if_addr = 16'h0040; if_rd = 1'b1;
    exp_q.push_back('{1'b0, 16'h0040, 16'h0000, 16'hBEEF, 3});
    if_q.push_back(16'hBEEF);
    stall_cnt = 0; n_strobe = 0;
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (s_if_done) break;
      if (s_if_stall) stall_cnt++;
    end
    check("t1_if_done", s_if_done, 1);
    check("t1_stall_cycles", stall_cnt, 4);
    check("t1_stall_low_on_done", s_if_stall, 0);
    check("t1_no_reissue", s_mem_rd, 0);
    if_rd = 1'b0;
    cycle();
    check("t1_strobe_count", n_strobe, 1);

    // 2: simultaneous write + fetch, data first, fetch granted in dm_done cycle
    if_addr = 16'h0080; if_rd = 1'b1;
    dm_addr = 16'h0100; dm_wdata = 16'h1234; dm_wr = 1'b1;
    exp_q.push_back('{1'b1, 16'h0100, 16'h1234, 16'h0000, 1});
    exp_q.push_back('{1'b0, 16'h0080, 16'h0000, 16'hCAFE, 2});
    dm_q.push_back(16'h0000);
    if_q.push_back(16'hCAFE);
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (s_dm_done) break;
    end
    check("t2_dm_done", s_dm_done, 1);
    check("t2_fetch_grant", s_mem_rd, 1);
    check("t2_fetch_grant_cycle", last_strobe, cyc);
    dm_wr = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (s_if_done) break;
    end
    check("t2_if_done", s_if_done, 1);
    if_rd = 1'b0;
    cycle();

    // 3: back-to-back loads, L=1
    dm_addr = 16'h0002; dm_rd = 1'b1;
    exp_q.push_back('{1'b0, 16'h0002, 16'h0000, 16'h1111, 1});
    dm_q.push_back(16'h1111);
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (s_dm_done) break;
    end
    check("t3_first_done", s_dm_done, 1);
    check("t3_dm_stall_on_done", s_dm_stall, 0);
    t0 = last_strobe;
    dm_addr = 16'h0004;
    exp_q.push_back('{1'b0, 16'h0004, 16'h0000, 16'h2222, 1});
    dm_q.push_back(16'h2222);
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (s_dm_done) break;
    end
    check("t3_second_done", s_dm_done, 1);
    check("t3_strobe_spacing", last_strobe - t0, 3);
    dm_rd = 1'b0;
    cycle();

    // 6: reset two cycles into DATA with a fetch pending
    dm_addr = 16'h0300; dm_rd = 1'b1;
    if_addr = 16'h0400; if_rd = 1'b1;
    exp_q.push_back('{1'b0, 16'h0300, 16'h0000, 16'hDEAD, 10});
    cycle();
    check("t6_data_grant", last_strobe, cyc);
    cycle();
    rst = 1'b1;
    #1;
    check("t6_async_dm_rdata", dm_rdata, 0);
    check("t6_async_if_rdata", if_rdata, 0);
    check("t6_async_err", err, 0);
    check("t6_async_dones", {if_done, dm_done}, 0);
    check("t6_async_strobes", {mem_rd, mem_wr}, 0);
    check("t6_async_mem_addr", mem_addr, 0);
    dm_rd = 1'b0;
    exp_q.delete();
    cycle();
    exp_q.push_back('{1'b0, 16'h0400, 16'h0000, 16'h7777, 1});
    if_q.push_back(16'h7777);
    rst = 1'b0;
    cycle();
    check("t6_fetch_first_cycle", s_mem_rd, 1);
    check("t6_fetch_grant_cycle", last_strobe, cyc);
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (s_if_done) break;
    end
    check("t6_if_done", s_if_done, 1);
    if_rd = 1'b0;
    cycle();

    // 4: timeout on a fetch, then re-grant of the held request
    if_addr = 16'h0200; if_rd = 1'b1;
    exp_q.push_back('{1'b0, 16'h0200, 16'h0000, 16'h0000, 0});
    exp_q.push_back('{1'b0, 16'h0200, 16'h0000, 16'h5A5A, 2});
    if_q.push_back(16'h5A5A);
    cycle();
    t0 = last_strobe;
    check("t4_grant", t0, cyc);
    bad_done = 0;
    for (int i = 0; i < 25; i++) begin
      cycle();
      if (s_if_done) bad_done++;
      if (s_err) break;
    end
    check("t4_err", s_err, 1);
    check("t4_timeout_cycles", cyc - t0, 17);
    check("t4_no_done", bad_done, 0);
    check("t4_regrant", last_strobe, cyc);
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (s_if_done) break;
    end
    check("t4_regrant_done", s_if_done, 1);
    if_rd = 1'b0;
    cycle();
    check("t4_err_sticky", s_err, 1);

    // 5a: read and write together
    do_reset(1'b1);
    dm_addr = 16'h0010; dm_rd = 1'b1; dm_wr = 1'b1;
    cycle();
    check("t5a_no_strobe", {s_mem_rd, s_mem_wr}, 0);
    check("t5a_err_before", s_err, 0);
    dm_rd = 1'b0; dm_wr = 1'b0;
    cycle();
    check("t5a_err", s_err, 1);

    // 5b: mem_done while idle
    do_reset(1'b1);
    inject_done = 1'b1;
    cycle();
    check("t5b_err_before", s_err, 0);
    cycle();
    check("t5b_err", s_err, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
